exe_stage_pipe: RTL

Parametrised execute stage for the RV32I/RV64I pipeline, sitting between the decode/register-read stage and the memory stage. It selects the ALU operands (register, PC or immediate), executes the full RV integer ALU op set, resolves branches, and computes the branch target as PC + immediate. All results are held in an output register with a valid/ready handshake and a flush input. Shifts can optionally run on a serial (1 bit/cycle) shifter to save area.

---
 rtl/exe_stage_pipe.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/exe_stage_pipe.sv
// Execute stage: operand select, RV integer ALU, branch resolve and target,
// single output register with valid/ready handshake and flush. Shifts may
// optionally run on an iterative 1-bit/cycle shifter.
module exe_stage_pipe #(
   parameter int XLEN         = 32,
   parameter int SERIAL_SHIFT = 0,
   parameter int SHAMT_W      = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   input  logic [4:0]      in_rd,
   input  logic [3:0]      in_alu_op,
   input  logic            in_src_a_pc,
   input  logic            in_src_b_imm,
   input  logic            in_is_branch,
   input  logic [2:0]      in_ctrl_mem,
   input  logic [1:0]      in_ctrl_wb,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_alu_result,
   output logic [XLEN-1:0] out_store_data,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_ctrl_mem,
   output logic [1:0]      out_ctrl_wb,
   output logic            out_zero,
   output logic            out_branch_taken,
   output logic [XLEN-1:0] out_branch_target
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FULL = 2'd1, S_SHIFT = 2'd2} state_t;

   state_t            state_q, state_d;
   logic              valid_q, valid_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic [XLEN-1:0]   store_q, store_d;
   logic [4:0]        rd_q, rd_d;
   logic [2:0]        mem_q, mem_d;
   logic [1:0]        wb_q, wb_d;
   logic              zero_q, zero_d;
   logic              taken_q, taken_d;
   logic [XLEN-1:0]   target_q, target_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]   sh_val_q, sh_val_d;
   logic              sh_left_q, sh_left_d;
   logic              sh_arith_q, sh_arith_d;

   logic [XLEN-1:0]   op_a, op_b, alu_res;
   logic [3:0]        alu_op;
   logic [SHAMT_W-1:0] shamt;
   logic              lt, ltu, eq, br_taken, is_shift, go_serial;
   logic              accept, drain;

   assign in_ready = (state_q != S_SHIFT) && !flush && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign drain    = valid_q && out_ready;

   // Operand select, ALU and branch condition for the incoming instruction.
   always_comb begin
      op_a     = (in_src_a_pc && !in_is_branch) ? in_pc : in_rs1;
      op_b     = (in_src_b_imm && !in_is_branch) ? in_imm : in_rs2;
      alu_op   = in_is_branch ? 4'b1000 : in_alu_op;
      shamt    = op_b[SHAMT_W-1:0];
      lt       = $signed(in_rs1) < $signed(in_rs2);
      ltu      = in_rs1 < in_rs2;
      eq       = in_rs1 == in_rs2;
      is_shift = !in_is_branch && (in_alu_op[1:0] == 2'b01);
      // With the serial shifter only shamt==0 shifts reach the one-cycle
      // path, so no barrel shifter is built in that configuration.
      go_serial = (SERIAL_SHIFT != 0) && is_shift && (shamt != '0);
      case (alu_op[2:0])
         3'b000:  alu_res = alu_op[3] ? (op_a - op_b) : (op_a + op_b);
         3'b001:  alu_res = op_a << shamt;
         3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         3'b011:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
         3'b100:  alu_res = op_a ^ op_b;
         3'b101:  alu_res = alu_op[3] ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
         3'b110:  alu_res = op_a | op_b;
         default: alu_res = op_a & op_b;
      endcase
      if (SERIAL_SHIFT != 0 && is_shift) alu_res = op_a;
      case (in_alu_op[2:0])
         3'b000:  br_taken = eq;
         3'b001:  br_taken = !eq;
         3'b100:  br_taken = lt;
         3'b101:  br_taken = !lt;
         3'b110:  br_taken = ltu;
         3'b111:  br_taken = !ltu;
         default: br_taken = 1'b0;
      endcase
      br_taken = br_taken && in_is_branch;
   end

   // Next-state for the FSM, output register and serial shifter.
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      res_d      = res_q;
      store_d    = store_q;
      rd_d       = rd_q;
      mem_d      = mem_q;
      wb_d       = wb_q;
      zero_d     = zero_q;
      taken_d    = taken_q;
      target_d   = target_q;
      cnt_d      = cnt_q;
      sh_val_d   = sh_val_q;
      sh_left_d  = sh_left_q;
      sh_arith_d = sh_arith_q;
      if (flush) begin
         state_d = S_IDLE;
         valid_d = 1'b0;
         cnt_d   = '0;
      end else if (state_q == S_SHIFT) begin
         if (cnt_q == '0) begin
            state_d = S_FULL;
            valid_d = 1'b1;
            res_d   = sh_val_q;
            zero_d  = (sh_val_q == '0);
         end else begin
            sh_val_d = sh_left_q ? {sh_val_q[XLEN-2:0], 1'b0}
                                 : {sh_arith_q & sh_val_q[XLEN-1], sh_val_q[XLEN-1:1]};
            cnt_d    = cnt_q - 1'b1;
         end
      end else if (accept) begin
         store_d  = in_rs2;
         rd_d     = in_rd;
         mem_d    = in_ctrl_mem;
         wb_d     = in_ctrl_wb;
         taken_d  = br_taken;
         target_d = in_pc + in_imm;
         if (go_serial) begin
            state_d    = S_SHIFT;
            valid_d    = 1'b0;
            sh_val_d   = op_a;
            cnt_d      = shamt;
            sh_left_d  = !in_alu_op[2];
            sh_arith_d = in_alu_op[3];
         end else begin
            state_d = S_FULL;
            valid_d = 1'b1;
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
         end
      end else if (drain) begin
         state_d = S_IDLE;
         valid_d = 1'b0;
      end
   end

   // State register; reset clears everything and overrides flush/handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         valid_q    <= 1'b0;
         res_q      <= '0;
         store_q    <= '0;
         rd_q       <= '0;
         mem_q      <= '0;
         wb_q       <= '0;
         zero_q     <= 1'b0;
         taken_q    <= 1'b0;
         target_q   <= '0;
         cnt_q      <= '0;
         sh_val_q   <= '0;
         sh_left_q  <= 1'b0;
         sh_arith_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         res_q      <= res_d;
         store_q    <= store_d;
         rd_q       <= rd_d;
         mem_q      <= mem_d;
         wb_q       <= wb_d;
         zero_q     <= zero_d;
         taken_q    <= taken_d;
         target_q   <= target_d;
         cnt_q      <= cnt_d;
         sh_val_q   <= sh_val_d;
         sh_left_q  <= sh_left_d;
         sh_arith_q <= sh_arith_d;
      end
   end

   assign out_valid         = valid_q;
   assign out_alu_result    = res_q;
   assign out_store_data    = store_q;
   assign out_rd            = rd_q;
   assign out_ctrl_mem      = mem_q;
   assign out_ctrl_wb       = wb_q;
   assign out_zero          = zero_q;
   assign out_branch_taken  = taken_q;
   assign out_branch_target = target_q;

endmodule
